// File: rtl/cam_diag_pkg.sv
// rtl/cam_diag_pkg.sv - shared widths, record layout and helpers for camera diagnostics
package cam_diag_pkg;

  localparam int LINE_W_DEF = 10;
  localparam int PIX_W_DEF  = 11;
  localparam int DROP_W_DEF = 8;

  // Record layout from MSB down: {drops, field, max, min, lines}
  function automatic int rec_width(input int line_w, input int pix_w, input int drop_w);
    return drop_w + 1 + 2 * pix_w + line_w;
  endfunction

  function automatic int off_lines();
    return 0;
  endfunction

  function automatic int off_min(input int line_w);
    return line_w;
  endfunction

  function automatic int off_max(input int line_w, input int pix_w);
    return line_w + pix_w;
  endfunction

  function automatic int off_field(input int line_w, input int pix_w);
    return line_w + 2 * pix_w;
  endfunction

  function automatic int off_drops(input int line_w, input int pix_w);
    return line_w + 2 * pix_w + 1;
  endfunction

endpackage

// File: rtl/cam_diag_fifo.sv
// rtl/cam_diag_fifo.sv - generic synchronous show-ahead FIFO, async active-low reset
module cam_diag_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/cam_field_stats_fifo.sv
// rtl/cam_field_stats_fifo.sv - per-field line/pixel statistics with record FIFO and drop count
module cam_field_stats_fifo
  import cam_diag_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int DEPTH  = 4,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                     cam_pclk,
  input  logic                     cam_resetn,
  input  logic                     cam_line_valid,
  input  logic                     cam_pix_en,
  input  logic                     cam_field_toggle,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [LINE_W-1:0]        out_lines,
  output logic [PIX_W-1:0]         out_pix_min,
  output logic [PIX_W-1:0]         out_pix_max,
  output logic                     out_field,
  output logic [DROP_W-1:0]        out_drops,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int REC_W = rec_width(LINE_W, PIX_W, DROP_W);
  localparam int O_LIN = off_lines();
  localparam int O_MIN = off_min(LINE_W);
  localparam int O_MAX = off_max(LINE_W, PIX_W);
  localparam int O_FLD = off_field(LINE_W, PIX_W);
  localparam int O_DRP = off_drops(LINE_W, PIX_W);

  localparam logic [LINE_W-1:0] LINE_MAX = '1;
  localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);
  localparam logic [PIX_W-1:0]  PIX_MAX  = '1;
  localparam logic [PIX_W-1:0]  PIX_ONE  = PIX_W'(1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic              line_d;
  logic              tog_d;
  logic              line_rise;
  logic              line_fall;
  logic              boundary;
  logic [LINE_W-1:0] lines_cnt;
  logic [PIX_W-1:0]  pix_cnt;
  logic [PIX_W-1:0]  min_acc;
  logic [PIX_W-1:0]  max_acc;
  logic [PIX_W-1:0]  min_nxt;
  logic [PIX_W-1:0]  max_nxt;
  logic [PIX_W-1:0]  rec_min;
  logic [PIX_W-1:0]  rec_max;
  logic [DROP_W-1:0] drop_cnt;
  logic [REC_W-1:0]  rec_in;
  logic [REC_W-1:0]  rec_head;
  logic [REC_W-1:0]  rec_out;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push_ok;

  assign line_rise = cam_line_valid && !line_d;
  assign line_fall = !cam_line_valid && line_d;
  assign boundary  = (cam_field_toggle != tog_d);
  assign pop       = out_valid && out_ready;
  assign push_ok   = !fifo_full || pop;

  // Folding the falling line in here lets a line ending on a boundary land in the closing record
  always_comb begin
    min_nxt = min_acc;
    max_nxt = max_acc;
    if (line_fall) begin
      if (pix_cnt < min_acc) min_nxt = pix_cnt;
      if (pix_cnt > max_acc) max_nxt = pix_cnt;
    end
  end

  assign rec_min = (lines_cnt == '0) ? '0 : min_nxt;
  assign rec_max = (lines_cnt == '0) ? '0 : max_nxt;
  assign rec_in  = {drop_cnt, tog_d, rec_max, rec_min, lines_cnt};

  always_ff @(posedge cam_pclk or negedge cam_resetn) begin
    if (!cam_resetn) begin
      line_d    <= 1'b0;
      tog_d     <= 1'b0;
      lines_cnt <= '0;
      pix_cnt   <= '0;
      min_acc   <= '1;
      max_acc   <= '0;
      drop_cnt  <= '0;
    end else begin
      line_d <= cam_line_valid;
      tog_d  <= cam_field_toggle;

      if (line_rise)
        pix_cnt <= cam_pix_en ? PIX_ONE : '0;
      else if (cam_line_valid && cam_pix_en && pix_cnt != PIX_MAX)
        pix_cnt <= pix_cnt + 1'b1;

      if (boundary) begin
        lines_cnt <= line_rise ? LINE_ONE : '0;
        min_acc   <= '1;
        max_acc   <= '0;
        if (push_ok)                  drop_cnt <= '0;
        else if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 1'b1;
      end else begin
        if (line_rise && lines_cnt != LINE_MAX) lines_cnt <= lines_cnt + 1'b1;
        min_acc <= min_nxt;
        max_acc <= max_nxt;
      end
    end
  end

  cam_diag_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (cam_pclk),
    .resetn    (cam_resetn),
    .push      (boundary),
    .push_data (rec_in),
    .pop       (pop),
    .pop_data  (rec_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign out_valid   = !fifo_empty;
  assign rec_out     = fifo_empty ? '0 : rec_head;
  assign out_lines   = rec_out[O_LIN +: LINE_W];
  assign out_pix_min = rec_out[O_MIN +: PIX_W];
  assign out_pix_max = rec_out[O_MAX +: PIX_W];
  assign out_field   = rec_out[O_FLD];
  assign out_drops   = rec_out[O_DRP +: DROP_W];

endmodule

// File: doc/cam_field_stats_fifo.md
# cam_field_stats_fifo

Per-field video timing statistics collector for the TVP5150 capture path, running in the `cam_pclk` domain. For each field it counts lines, measures the minimum and maximum active pixels per line, and tags the field parity. Completed field records go into a small FIFO. The FIFO drains to the I2C/serial logger over a valid/ready handshake, so no field is lost while the logger is busy unless the FIFO overflows. Overflows are counted and reported in-band.

## Interface
Parameters:
- `LINE_W`, 10: line-counter width; saturates at 2^LINE_W-1.
- `PIX_W`, 11: pixels-per-line counter width; saturates at 2^PIX_W-1.
- `DEPTH`, 4: FIFO depth in records; power of two, ≥2.
- `DROP_W`, 8: dropped-record counter width; saturating.

Ports:
- `cam_pclk`, in, 1: clock.
- `cam_resetn`, in, 1: reset, asynchronous, active-low.
- `cam_line_valid`, in, 1: active-line qualifier from capture.
- `cam_pix_en`, in, 1: pixel strobe; a pixel counts when `cam_line_valid && cam_pix_en`.
- `cam_field_toggle`, in, 1: toggles once per field boundary; its level is the parity of the new field.
- `out_ready`, in, 1: logger accepts the head record.
- `out_valid`, out, 1: head record available.
- `out_lines`, out, LINE_W: lines in the field.
- `out_pix_min`, out, PIX_W: minimum pixels per line in the field.
- `out_pix_max`, out, PIX_W: maximum pixels per line in the field.
- `out_field`, out, 1: parity of the field the record describes.
- `out_drops`, out, DROP_W: records dropped since the previous accepted push.
- `fifo_level`, out, $clog2(DEPTH)+1: current occupancy.

## Operation
- Edge detection uses registered copies of `cam_line_valid` and `cam_field_toggle`. Both registers reset to 0.
- Line rising edge: `lines_cnt` +1 (saturating) and `pix_cnt` cleared. If `cam_pix_en` is also high that cycle, `pix_cnt` loads 1.
- While `cam_line_valid` is high: `pix_cnt` +1 (saturating) on each `cam_pix_en`.
- Line falling edge: the final `pix_cnt` updates `min_acc` and `max_acc`.
  - `min_acc` initialises to all-ones and `max_acc` to 0 at reset and at each field start.
- Field boundary (`cam_field_toggle` ≠ its delayed copy): build record {`lines_cnt`, `min_acc`, `max_acc`, parity = delayed toggle value, `drop_cnt`}, then push it.
  - Accumulators restart for the new field.
  - If `lines_cnt == 0`, the record reports `pix_min = 0` and `pix_max = 0`.
- Simultaneous events in one cycle:
  - Line falling edge + field boundary: that line's pixel count goes into the closing record.
  - Line rising edge + field boundary: that line counts as line 1 of the new field.
  - A line still active across a boundary: its pixels belong to the new field.
- Push behaviour:
  - FIFO not full, or full with a pop in the same cycle: push accepted and `drop_cnt` cleared.
  - Otherwise: record discarded and `drop_cnt` +1 (saturating at all-ones).
- Pop occurs when `out_valid && out_ready`. The FIFO is show-ahead: `out_*` always present the head entry.
- `out_*` data are don't-care while `out_valid` = 0, but must stay stable while `out_valid && !out_ready`.
- Reset mid-field: all counters, the FIFO, `drop_cnt` and outputs return to reset values immediately. The partial field is discarded.

## Timing
- Reset values: `out_valid` = 0, all `out_*` = 0, `fifo_level` = 0.
- Boundary detected in cycle N (compare of input against its delayed copy): record written at the clock edge ending cycle N.
  - If the FIFO was empty, `out_valid` = 1 and `fifo_level` = 1 in cycle N+1.
- Pop in cycle M: the next record, or `out_valid` = 0, appears in cycle M+1.
- `fifo_level` updates on the same edge as the push/pop. A push and pop in the same cycle leave it unchanged.
- The first boundary after reset produces a record (the partial first field). The verifier must expect it.

## Structure
- Shared package `cam_diag_pkg` holds:
  - default widths: `LINE_W`, `PIX_W`, `DROP_W`;
  - record packing offsets, in order {drops, field, max, min, lines} from MSB down;
  - the record-width function.
- Sub-module `cam_diag_fifo`: generic synchronous show-ahead FIFO with parameters WIDTH and DEPTH, ports `push`/`pop`/`full`/`empty`/`level`, async active-low reset.
- The top level contains edge detection, the accumulators, record packing and drop logic.

## Test plan
- Reset, then 3 fields of 5 lines × 720 pixels with `out_ready` = 1: 3 records, each lines = 5, min = max = 720, parity alternating with the toggle; first record = partial field.
- Line lengths 700/720/710 in one field: min = 700, max = 720.
- `out_ready` = 0 for 6 fields with DEPTH = 4: level reaches 4, the next 2 fields are dropped; release ready, then the next field's record has drops = 2 and the following one drops = 0.
- Field boundary in the same cycle as a line falling edge of 640 pixels: that line is counted in the closing record (lines and min/max include 640).
- Field with 0 lines: record lines = 0, min = 0, max = 0; a 2100-pixel line at PIX_W = 11 reports max = 2047 (saturated).
- `cam_resetn` asserted with 2 records queued and a field half-counted: `out_valid` = 0 and level = 0 immediately; after release, the first record reflects only post-reset lines.
